irq_trap_ctrl: RTL and testbench
================================

// Module: irq_trap_ctrl
// PURPOSE
// Core-side receiver of the memory-mapped timer/software interrupt lines plus the
// external line. Holds M-mode interrupt CSRs (mstatus, mie, mip, mtvec, mepc, mcause),
// arbitrates pending interrupts, handshakes a trap with the pipeline, redirects fetch
// to the handler and restores state on mret. Sits between the mapped CLINT and decode/CSR stage.
// PARAMETERS
// XLEN        32       data/CSR width
// RESET_MTVEC 32'h0    mtvec reset value (mode bits 0 = direct)
// PORTS
// clk            in   1     clock
// rst            in   1     synchronous reset, active-high
// time_interrupt in   1     timer interrupt level (MTIP source)
// msip           in   1     software interrupt level (MSIP source)
// ext_irq        in   1     external interrupt level (MEIP source)
// csr_we         in   1     CSR write strobe
// csr_addr       in   12    CSR address
// csr_wdata      in   XLEN  CSR write data
// csr_rdata      out  XLEN  CSR read data, registered
// epc_in         in   XLEN  PC of next instruction to execute (saved to mepc)
// pc_valid       in   1     epc_in valid; pipeline can accept a trap
// trap_req       out  1     interrupt trap requested
// trap_ack       in   1     pipeline flushed at boundary, trap accepted
// mret           in   1     mret retiring (1-cycle pulse)
// redirect_valid out  1     1-cycle fetch redirect pulse
// redirect_pc    out  XLEN  redirect target
// BEHAVIOUR
// - Reset: csr_rdata=0, trap_req=0, redirect_valid=0, redirect_pc=0; mstatus.MIE/MPIE=0,
//   mie=0, mip=0, mepc=0, mcause=0, mtvec=RESET_MTVEC, FSM=IDLE.
// - mip: bits 11/7/3 = ext_irq/time_interrupt/msip, sampled one flop per cycle; read-only.
// - mie: only bits 11,7,3 writable; others read 0. mstatus: MIE(3), MPIE(7) writable,
//   MPP[12:11] reads 2'b11, rest 0. mepc[1:0] forced 0. mcause fully writable.
// - mtvec: write with mode 2/3 updates base[31:2], keeps old mode.
// - CSR map: 300 mstatus, 304 mie, 305 mtvec, 341 mepc, 342 mcause, 344 mip; others
//   read 0, writes ignored. csr_rdata = value of csr_addr one cycle later (pre-write value).
// - pend = mip & mie & {MIE}; priority MEI(11) > MSI(3) > MTI(7).
// - FSM IDLE: pend!=0 && pc_valid -> REQ, latch cause code. mret -> redirect_valid=1,
//   redirect_pc=mepc next cycle; MIE<=MPIE, MPIE<=1.
// - REQ: trap_req=1; cause committed (no withdrawal if line/enable drops). trap_ack ->
//   mepc<=epc_in&~3, mcause<={1'b1,27'b0,code}, MPIE<=MIE, MIE<=0, -> REDIR.
// - REDIR: redirect_valid=1 for exactly 1 cycle; redirect_pc = base (direct) or
//   base+4*code (vectored); -> IDLE. trap_req low. Earliest new request: cycle after REDIR.
// - Trap path = 3 cycles min: IDLE->REQ (ack same cycle as first req) ->REDIR->IDLE.
// - Simultaneous: trap_ack and CSR write to mstatus/mepc/mcause -> trap update wins.
//   trap_ack with mret -> trap wins, mret ignored (bench asserts never occurs).
//   mret outside IDLE ignored. trap_ack outside REQ ignored.
// - Reset mid-operation: any state -> IDLE, all outputs to reset values next edge.
// STRUCTURE
// - Shared package riscv_csr_pkg: CSR address constants, interrupt cause codes
//   (3/7/11), mstatus bit indices, trap FSM state enum.
// - Sub-module irq_prio_enc: combinational pend[11:0] -> {any, code[3:0]} fixed-priority.
// TESTING
// - Reset: rst=1 2 cycles -> all outputs 0, read 305 -> RESET_MTVEC, read 300 -> 32'h1800.
// - Direct MTI: mtvec=0x100, mie=0x80, mstatus=0x8, time_interrupt=1, ack next cycle ->
//   mepc=epc_in(0x2004), mcause=0x80000007, redirect_pc=0x100, mstatus=0x1880.
// - Vectored priority: mtvec=0x201, mie=0x888, ext_irq=msip=1 same cycle -> code 11,
//   redirect_pc=0x22C; after mret and MIE=1, msip still high -> redirect_pc=0x20C.
// - Masking: mstatus.MIE=0, all lines+mie set -> trap_req stays 0 100 cycles; set MIE
//   -> trap_req within 2 cycles.
// - mret: mepc=0x3000, MPIE=1 -> redirect_pc=0x3000, MIE=1, MPIE=1; mtvec write
//   0x402 over mode 1 -> reads 0x401.
// - Reset in REQ: trap_req=1, rst pulse -> trap_req=0, no redirect, mepc unchanged (0).

Source files
------------

// File: rtl/riscv_csr_pkg.sv
// Shared M-mode CSR definitions: addresses, interrupt cause codes, mstatus
// bit positions and the trap handshake state encoding.
package riscv_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // Only the three machine-level interrupt sources exist in mie/mip
  localparam logic [11:0] IRQ_MASK = 12'h888;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    TRAP_IDLE  = 2'd0,
    TRAP_REQ   = 2'd1,
    TRAP_REDIR = 2'd2
  } trap_state_t;

  function automatic logic mtvec_mode_legal(input logic [1:0] mode);
    return (mode == MTVEC_DIRECT) || (mode == MTVEC_VECTORED);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI; any other pending bit
// falls back to highest-index-wins so the encoder is total over pend[11:0].
module irq_prio_enc
  import riscv_csr_pkg::*;
(
  input  logic [11:0] pend,
  output logic        any,
  output logic [3:0]  code
);

  always_comb begin
    any  = |pend;
    code = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (pend[i]) code = i[3:0];
    end
    // Later assignments win, giving MEI the highest priority
    if (pend[IRQ_MTI]) code = IRQ_MTI;
    if (pend[IRQ_MSI]) code = IRQ_MSI;
    if (pend[IRQ_MEI]) code = IRQ_MEI;
  end

endmodule

// File: rtl/irq_trap_ctrl.sv
// M-mode interrupt CSRs plus the trap/mret handshake with the pipeline:
// arbitrates pending interrupts, requests a trap and redirects fetch.
module irq_trap_ctrl
  import riscv_csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            time_interrupt,
  input  logic            msip,
  input  logic            ext_irq,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] epc_in,
  input  logic            pc_valid,
  output logic            trap_req,
  input  logic            trap_ack,
  input  logic            mret,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  trap_state_t     r_state, w_state_next;
  logic [3:0]      r_code, w_code_next;
  logic            r_mstatus_mie, r_mstatus_mpie;
  logic [11:0]     r_mie, r_mip;
  logic [XLEN-1:0] r_mtvec, r_mepc, r_mcause;
  logic [XLEN-1:0] r_csr_rdata;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  logic [11:0]     w_pend;
  logic            w_any;
  logic [3:0]      w_enc_code;
  logic            w_take_ack, w_take_mret;
  logic [XLEN-1:0] w_mstatus, w_rdata, w_trap_pc, w_mtvec_base, w_cause;

  assign w_pend = r_mip & r_mie & {12{r_mstatus_mie}};

  irq_prio_enc u_prio (
    .pend (w_pend),
    .any  (w_any),
    .code (w_enc_code)
  );

  assign w_take_ack  = (r_state == TRAP_REQ) && trap_ack;
  assign w_take_mret = (r_state == TRAP_IDLE) && mret;

  assign w_mtvec_base = r_mtvec & ALIGN_MASK;
  assign w_trap_pc    = (r_mtvec[1:0] == MTVEC_VECTORED)
                      ? w_mtvec_base + {{(XLEN-6){1'b0}}, r_code, 2'b00}
                      : w_mtvec_base;
  assign w_cause      = {1'b1, {(XLEN-5){1'b0}}, r_code};

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    case (r_state)
      TRAP_IDLE: begin
        // A retiring mret owns this cycle; pending work is seen next cycle
        if (!mret && w_any && pc_valid) begin
          w_state_next = TRAP_REQ;
          w_code_next  = w_enc_code;
        end
      end
      TRAP_REQ: begin
        if (trap_ack) w_state_next = TRAP_REDIR;
      end
      TRAP_REDIR: w_state_next = TRAP_IDLE;
      default:    w_state_next = TRAP_IDLE;
    endcase
  end

  always_comb begin
    w_mstatus                               = '0;
    w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    w_mstatus[MSTATUS_MIE]                  = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE]                 = r_mstatus_mpie;
  end

  always_comb begin
    w_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: w_rdata = w_mstatus;
      CSR_MIE:     w_rdata = {{(XLEN-12){1'b0}}, r_mie};
      CSR_MTVEC:   w_rdata = r_mtvec;
      CSR_MEPC:    w_rdata = r_mepc;
      CSR_MCAUSE:  w_rdata = r_mcause;
      CSR_MIP:     w_rdata = {{(XLEN-12){1'b0}}, r_mip};
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TRAP_IDLE;
      r_code  <= 4'd0;
      r_mip   <= '0;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_mip   <= {ext_irq, 3'b000, time_interrupt, 3'b000, msip, 3'b000};
    end
  end

  // CSR state: software writes first, mret/trap updates last so they win
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= RESET_MTVEC;
      r_mepc         <= '0;
      r_mcause       <= '0;
    end else begin
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= csr_wdata[MSTATUS_MIE];
            r_mstatus_mpie <= csr_wdata[MSTATUS_MPIE];
          end
          CSR_MIE:    r_mie <= csr_wdata[11:0] & IRQ_MASK;
          CSR_MTVEC: begin
            if (mtvec_mode_legal(csr_wdata[1:0]))
              r_mtvec <= csr_wdata;
            else
              r_mtvec <= {csr_wdata[XLEN-1:2], r_mtvec[1:0]};
          end
          CSR_MEPC:   r_mepc   <= csr_wdata & ALIGN_MASK;
          CSR_MCAUSE: r_mcause <= csr_wdata;
          default: ;
        endcase
      end
      if (w_take_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end
      if (w_take_ack) begin
        r_mepc         <= epc_in & ALIGN_MASK;
        r_mcause       <= w_cause;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csr_rdata      <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_csr_rdata      <= w_rdata;
      r_redirect_valid <= 1'b0;
      if (w_take_mret) begin
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= r_mepc;
      end
      if (w_take_ack) begin
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= w_trap_pc;
      end
    end
  end

  assign csr_rdata      = r_csr_rdata;
  assign trap_req       = (r_state == TRAP_REQ);
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl: CSR access, trap entry/exit, priority,
// masking and reset in the middle of a trap request.
module tb_irq_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        time_interrupt, msip, ext_irq;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic [31:0] epc_in;
  logic        pc_valid, trap_req, trap_ack, mret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_total = 0;
  int n_bad   = 0;

  irq_trap_ctrl #(.XLEN(32), .RESET_MTVEC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .time_interrupt (time_interrupt),
    .msip           (msip),
    .ext_irq        (ext_irq),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .epc_in         (epc_in),
    .pc_valid       (pc_valid),
    .trap_req       (trap_req),
    .trap_ack       (trap_ack),
    .mret           (mret),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    csr_we   = 1'b0;
    csr_addr = a;
    tick();
    d = csr_rdata;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!trap_req && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Wait for a request, ack it on its first cycle, check the redirect pulse
  task automatic do_trap(input string tag, input logic [31:0] exp_pc);
    wait_req(10);
    chk({tag, " trap_req"}, {31'b0, trap_req}, 32'h1);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk({tag, " redir_valid"}, {31'b0, redirect_valid}, 32'h1);
    chk({tag, " redir_pc"}, redirect_pc, exp_pc);
    chk({tag, " req_low_in_redir"}, {31'b0, trap_req}, 32'h0);
    tick();
    chk({tag, " redir_1cycle"}, {31'b0, redirect_valid}, 32'h0);
  endtask

  logic [31:0] rd;
  logic        seen;

  initial begin
    rst = 1'b1;
    time_interrupt = 0; msip = 0; ext_irq = 0;
    csr_we = 0; csr_addr = '0; csr_wdata = '0;
    epc_in = '0; pc_valid = 0; trap_ack = 0; mret = 0;
    tick();
    tick();
    chk("rst csr_rdata", csr_rdata, 32'h0);
    chk("rst trap_req", {31'b0, trap_req}, 32'h0);
    chk("rst redir_valid", {31'b0, redirect_valid}, 32'h0);
    chk("rst redir_pc", redirect_pc, 32'h0);
    rst = 1'b0;
    csr_read(12'h305, rd); chk("rst mtvec", rd, 32'h0);
    csr_read(12'h300, rd); chk("rst mstatus", rd, 32'h1800);

    // Direct-mode timer interrupt
    pc_valid = 1'b1;
    csr_write(12'h305, 32'h100);
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h8);
    epc_in = 32'h2004;
    time_interrupt = 1'b1;
    do_trap("mti", 32'h100);
    time_interrupt = 1'b0;
    csr_read(12'h341, rd); chk("mti mepc", rd, 32'h2004);
    csr_read(12'h342, rd); chk("mti mcause", rd, 32'h80000007);
    csr_read(12'h300, rd); chk("mti mstatus", rd, 32'h1880);

    // Vectored mode, MEI beats MSI; MSI taken after mret re-enables
    csr_write(12'h305, 32'h201);
    csr_write(12'h304, 32'h888);
    csr_write(12'h300, 32'h8);
    epc_in = 32'h1008;
    ext_irq = 1'b1; msip = 1'b1;
    do_trap("vec_mei", 32'h22C);
    csr_read(12'h342, rd); chk("vec mcause", rd, 32'h8000000B);
    ext_irq = 1'b0;
    tick();
    tick();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("vec mret redir_valid", {31'b0, redirect_valid}, 32'h1);
    chk("vec mret redir_pc", redirect_pc, 32'h1008);
    do_trap("vec_msi", 32'h20C);
    msip = 1'b0;
    csr_read(12'h342, rd); chk("vec msi mcause", rd, 32'h80000003);

    // Masking: global MIE off holds everything back
    csr_write(12'h300, 32'h0);
    ext_irq = 1'b1; msip = 1'b1; time_interrupt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (trap_req) seen = 1'b1;
    end
    chk("mask no req 100cyc", {31'b0, seen}, 32'h0);
    csr_read(12'h344, rd); chk("mip all lines", rd, 32'h888);
    // pc_valid low also holds the request back
    pc_valid = 1'b0;
    csr_write(12'h300, 32'h8);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (trap_req) seen = 1'b1;
    end
    chk("pc_valid low no req", {31'b0, seen}, 32'h0);
    csr_write(12'h300, 32'h0);
    pc_valid = 1'b1;
    tick();
    csr_write(12'h300, 32'h8);
    wait_req(2);
    chk("unmask req within 2", {31'b0, trap_req}, 32'h1);
    do_trap("mask_mei", 32'h22C);
    ext_irq = 1'b0; msip = 1'b0; time_interrupt = 1'b0;
    tick();
    tick();

    // mret restores from mepc; CSR field behaviour
    csr_write(12'h341, 32'h3000);
    csr_write(12'h300, 32'h80);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("mret redir_valid", {31'b0, redirect_valid}, 32'h1);
    chk("mret redir_pc", redirect_pc, 32'h3000);
    csr_read(12'h300, rd); chk("mret mstatus", rd, 32'h1888);
    csr_write(12'h305, 32'h402);
    csr_read(12'h305, rd); chk("mtvec keep mode", rd, 32'h401);
    csr_write(12'h341, 32'h3003);
    csr_read(12'h341, rd); chk("mepc align", rd, 32'h3000);
    csr_write(12'h304, 32'hFFFF_FFFF);
    csr_read(12'h304, rd); chk("mie mask", rd, 32'h888);
    csr_write(12'h7C0, 32'h1234);
    csr_read(12'h7C0, rd); chk("unmapped csr", rd, 32'h0);
    // Stray ack outside REQ does nothing
    csr_write(12'h304, 32'h0);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("stray ack no redir", {31'b0, redirect_valid}, 32'h0);

    // Reset while a request is outstanding
    csr_write(12'h304, 32'h80);
    time_interrupt = 1'b1;
    wait_req(10);
    chk("pre-rst trap_req", {31'b0, trap_req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    time_interrupt = 1'b0;
    chk("rst-in-req trap_req", {31'b0, trap_req}, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (redirect_valid) seen = 1'b1;
      tick();
    end
    chk("rst-in-req no redir", {31'b0, seen}, 32'h0);
    csr_read(12'h341, rd); chk("rst-in-req mepc", rd, 32'h0);
    csr_read(12'h300, rd); chk("rst-in-req mstatus", rd, 32'h1800);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Trap acceptance and mret retirement must never coincide
  always @(posedge clk) begin
    if (!rst) assert (!(trap_ack && mret)) else $error("trap_ack with mret");
  end

endmodule
